// File: rtl/riscv_pkg.sv
// Shared RV32 decode constants for the EXE stage: ALU op classes, M-extension
// funct3/funct7 codes and the multiply/divide sequencer state type.
package riscv_pkg;

  localparam logic [2:0] ALU_OP_R_TYPE  = 3'b000;
  localparam logic [2:0] ALU_OP_I_TYPE  = 3'b001;
  localparam logic [2:0] ALU_OP_LOAD    = 3'b010;
  localparam logic [2:0] ALU_OP_STORE   = 3'b011;
  localparam logic [2:0] ALU_OP_BRANCH  = 3'b100;

  localparam logic [6:0] FUNCT7_MULDIV  = 7'b0000001;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {IDLE, CALC, DONE} muldiv_state_t;

  function automatic logic rs1_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) ||
           (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

  function automatic logic rs2_is_signed(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_DIV) || (f3 == F3_REM);
  endfunction

endpackage

// File: rtl/muldiv_dp.sv
// Datapath for the M-extension sequencer: shared product/remainder accumulator,
// restoring-divide trial subtractor, iteration counter, sign fix-up and result mux.
module muldiv_dp
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            step,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  output logic            fast,
  output logic            last,
  output logic [XLEN-1:0] result
);

  // acc upper half is the running product high word / remainder,
  // lower half is the multiplier being shifted out / dividend becoming quotient.
  logic [2*XLEN-1:0] acc;
  logic [XLEN-1:0]   b_mag;
  logic [XLEN-1:0]   fast_val;
  logic [CNT_W-1:0]  cnt;
  logic [2:0]        op_q;
  logic              sa_q, sb_q, fast_q;

  logic              sa, sb;
  logic [XLEN-1:0]   a_mag_in, b_mag_in;
  logic              by_zero, ovf;
  logic [XLEN-1:0]   fast_in;

  assign sa       = rs1_is_signed(funct3) & rs1_data[XLEN-1];
  assign sb       = rs2_is_signed(funct3) & rs2_data[XLEN-1];
  assign a_mag_in = sa ? -rs1_data : rs1_data;
  assign b_mag_in = sb ? -rs2_data : rs2_data;

  assign by_zero = (rs2_data == '0);
  assign ovf     = ((funct3 == F3_DIV) || (funct3 == F3_REM)) &&
                   (rs1_data == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_data == '1);
  assign fast    = funct3[2] & (by_zero | ovf);

  always_comb begin
    fast_in = '0;
    if (by_zero) fast_in = funct3[1] ? rs1_data : '1;
    else         fast_in = funct3[1] ? '0 : rs1_data;
  end

  logic [XLEN:0]   add_sum;
  logic [XLEN:0]   trial;
  logic [XLEN:0]   low_sub;
  logic            ge;
  logic [XLEN-1:0] rem_next;

  assign add_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, b_mag} : {(XLEN+1){1'b0}});
  assign trial    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
  // trial < 2*b_mag, so a set top bit already means trial >= b_mag
  assign low_sub  = {1'b0, trial[XLEN-1:0]} - {1'b0, b_mag};
  assign ge       = trial[XLEN] | ~low_sub[XLEN];
  assign rem_next = ge ? low_sub[XLEN-1:0] : trial[XLEN-1:0];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc      <= '0;
      b_mag    <= '0;
      fast_val <= '0;
      cnt      <= '0;
      op_q     <= '0;
      sa_q     <= 1'b0;
      sb_q     <= 1'b0;
      fast_q   <= 1'b0;
    end else if (load) begin
      acc      <= {{XLEN{1'b0}}, a_mag_in};
      b_mag    <= b_mag_in;
      fast_val <= fast_in;
      cnt      <= '0;
      op_q     <= funct3;
      sa_q     <= sa;
      sb_q     <= sb;
      fast_q   <= fast;
    end else if (step) begin
      cnt <= cnt + CNT_W'(1);
      if (op_q[2]) acc <= {rem_next, acc[XLEN-2:0], ge};
      else         acc <= {add_sum, acc[XLEN-1:1]};
    end
  end

  assign last = (cnt == CNT_W'(XLEN-1));

  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign prod_fix = (sa_q ^ sb_q) ? -acc : acc;
  assign quo_fix  = (sa_q ^ sb_q) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem_fix  = sa_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    result = '0;
    if (fast_q) begin
      result = fast_val;
    end else begin
      case (op_q)
        F3_MUL:                      result = prod_fix[XLEN-1:0];
        F3_MULH, F3_MULHSU, F3_MULHU: result = prod_fix[2*XLEN-1:XLEN];
        F3_DIV, F3_DIVU:             result = quo_fix;
        default:                     result = rem_fix;
      endcase
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// EXE-stage multi-cycle sequencer for RV32M: decodes M ops, stalls the pipe
// while the iterative datapath runs, then returns one registered result.
//
//   state | meaning
//   IDLE  | waiting for an M op; accepting one raises m_stall this cycle
//   CALC  | one shift-add / restoring-divide iteration per cycle, stalled
//   DONE  | result fixed up and registered; pipe released, no new accept
module muldiv_seq
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            m_valid,
  input  logic [2:0]      exe_alu_op,
  input  logic [2:0]      exe_funct3,
  input  logic [6:0]      exe_funct7,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            flush,
  output logic            m_stall,
  output logic            m_done,
  output logic [XLEN-1:0] m_result
);

  muldiv_state_t   state;
  logic            is_m, start;
  logic            dp_fast, dp_last;
  logic [XLEN-1:0] dp_result;

  assign is_m    = (exe_alu_op == ALU_OP_R_TYPE) && (exe_funct7 == FUNCT7_MULDIV);
  assign start   = m_valid && is_m && (state == IDLE) && !flush;
  assign m_stall = !flush && (start || (state == CALC));

  muldiv_dp #(
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_dp (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (start),
    .step     (state == CALC),
    .funct3   (exe_funct3),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .fast     (dp_fast),
    .last     (dp_last),
    .result   (dp_result)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      m_done   <= 1'b0;
      m_result <= '0;
    end else begin
      m_done <= 1'b0;
      case (state)
        IDLE: if (start) state <= dp_fast ? DONE : CALC;
        CALC: begin
          if (flush)        state <= IDLE;
          else if (dp_last) state <= DONE;
        end
        DONE: begin
          state <= IDLE;
          if (!flush) begin
            m_result <= dp_result;
            m_done   <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: expected results and latencies are queued
// at accept time and matched against each m_done pulse.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        m_valid;
  logic [2:0]  exe_alu_op;
  logic [2:0]  exe_funct3;
  logic [6:0]  exe_funct7;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        m_stall;
  logic        m_done;
  logic [31:0] m_result;

  muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .m_valid    (m_valid),
    .exe_alu_op (exe_alu_op),
    .exe_funct3 (exe_funct3),
    .exe_funct7 (exe_funct7),
    .rs1_data   (rs1_data),
    .rs2_data   (rs2_data),
    .flush      (flush),
    .m_stall    (m_stall),
    .m_done     (m_done),
    .m_result   (m_result)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [31:0] res;
    int          lat;
    int          acc_cyc;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  logic [31:0] last_result = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (m_done === 1'b1) begin
      tests++;
      if (sb_q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_done: m_done=1 m_result=%h, required no done", m_result);
      end else begin
        mon_e = sb_q.pop_front();
        if (m_result !== mon_e.res || (cyc - mon_e.acc_cyc) != mon_e.lat) begin
          fails++;
          $display("FAIL %s: result=%h latency=%0d, required result=%h latency=%0d",
                   mon_e.name, m_result, cyc - mon_e.acc_cyc, mon_e.res, mon_e.lat);
        end
        last_result = mon_e.res;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic drive_m(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    m_valid    = 1'b1;
    exe_alu_op = 3'b000;
    exe_funct7 = 7'b0000001;
    exe_funct3 = f3;
    rs1_data   = a;
    rs2_data   = b;
  endtask

  // Holds the instruction in EXE until the stall drops, like a frozen pipeline.
  task automatic issue(input string name, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp_res, input int lat);
    int n;
    @(negedge clk);
    drive_m(f3, a, b);
    #1;
    tests++;
    if (m_stall !== 1'b1) begin
      fails++;
      $display("FAIL %s_stall_accept: m_stall=%b, required 1", name, m_stall);
    end
    @(posedge clk);
    #1;
    sb_q.push_back('{name: name, res: exp_res, lat: lat, acc_cyc: cyc});
    n = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (m_stall !== 1'b1) break;
      n++;
    end
    tests++;
    if (n != lat) begin
      fails++;
      $display("FAIL %s_stall_cycles: stalled=%0d, required %0d", name, n, lat);
    end
  endtask

  task automatic idle_drain();
    @(negedge clk);
    m_valid = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (sb_q.size() == 0) break;
      @(negedge clk);
    end
    tests++;
    if (sb_q.size() != 0) begin
      fails++;
      $display("FAIL drain_timeout: pending=%0d, required 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tests++;
    if (m_stall !== 1'b0 || m_done !== 1'b0 || m_result !== 32'h0) begin
      fails++;
      $display("FAIL reset_state: stall=%b done=%b result=%h, required 0 0 00000000",
               m_stall, m_done, m_result);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    issue("mul_7_neg3",      3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 33);
    issue("mulhu_ones",      3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33);
    issue("mulh_ones",       3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 33);
    issue("mulhsu_neg1_2",   3'b010, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 33);
    idle_drain();
  endtask

  task automatic test_div();
    issue("div_neg7_2",  3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33);
    issue("rem_neg7_2",  3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33);
    issue("divu_100_7",  3'b101, 32'd100,      32'd7, 32'd14,       33);
    issue("remu_100_7",  3'b111, 32'd100,      32'd7, 32'd2,        33);
    idle_drain();
  endtask

  task automatic test_fast();
    issue("div_by_zero",  3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    issue("remu_by_zero", 3'b111, 32'd5,        32'd0,        32'd5,        1);
    issue("div_overflow", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    issue("rem_overflow", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1);
    idle_drain();
  endtask

  task automatic test_flush();
    logic [31:0] held;
    held = last_result;
    // flush ten cycles into CALC
    @(negedge clk);
    drive_m(3'b000, 32'h1234, 32'h5678);
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    flush   = 1'b1;
    m_valid = 1'b0;
    #1;
    tests++;
    if (m_stall !== 1'b0) begin
      fails++;
      $display("FAIL flush_calc_stall: m_stall=%b, required 0", m_stall);
    end
    @(negedge clk);
    flush = 1'b0;
    tests++;
    if (m_result !== held) begin
      fails++;
      $display("FAIL flush_result_held: m_result=%h, required %h", m_result, held);
    end
    issue("mul_after_flush", 3'b000, 32'd3, 32'd4, 32'd12, 33);
    idle_drain();

    // flush and start together: nothing accepted
    @(negedge clk);
    drive_m(3'b000, 32'd9, 32'd9);
    flush = 1'b1;
    #1;
    tests++;
    if (m_stall !== 1'b0) begin
      fails++;
      $display("FAIL flush_start_stall: m_stall=%b, required 0", m_stall);
    end
    @(negedge clk);
    flush   = 1'b0;
    m_valid = 1'b0;
    #1;
    tests++;
    if (m_stall !== 1'b0) begin
      fails++;
      $display("FAIL flush_start_accepted: m_stall=%b, required 0", m_stall);
    end

    // flush while in DONE of a fast op
    held = last_result;
    @(negedge clk);
    drive_m(3'b101, 32'd9, 32'd0);
    @(negedge clk);
    flush   = 1'b1;
    m_valid = 1'b0;
    @(negedge clk);
    flush = 1'b0;
    repeat (40) @(negedge clk);
    tests++;
    if (m_result !== held) begin
      fails++;
      $display("FAIL flush_done_result: m_result=%h, required %h", m_result, held);
    end
  endtask

  task automatic test_back_to_back();
    issue("b2b_mul", 3'b000, 32'd6,   32'd7,        32'd42,       33);
    issue("b2b_div", 3'b100, 32'd100, 32'hFFFFFFFD, 32'hFFFFFFDF, 33);
    idle_drain();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    drive_m(3'b101, 32'd1000, 32'd3);
    @(posedge clk);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst_n   = 1'b0;
    m_valid = 1'b0;
    @(negedge clk);
    tests++;
    if (m_stall !== 1'b0 || m_done !== 1'b0 || m_result !== 32'h0) begin
      fails++;
      $display("FAIL reset_mid_op: stall=%b done=%b result=%h, required 0 0 00000000",
               m_stall, m_done, m_result);
    end
    rst_n = 1'b1;
    last_result = 32'h0;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_non_m();
    @(negedge clk);
    m_valid    = 1'b1;
    exe_alu_op = 3'b000;
    exe_funct7 = 7'b0000000;
    exe_funct3 = 3'b000;
    rs1_data   = 32'd1;
    rs2_data   = 32'd2;
    for (int i = 0; i < 3; i++) begin
      #1;
      tests++;
      if (m_stall !== 1'b0) begin
        fails++;
        $display("FAIL add_stall: m_stall=%b, required 0", m_stall);
      end
      @(negedge clk);
    end
    exe_alu_op = 3'b001;
    exe_funct7 = 7'b0000001;
    #1;
    tests++;
    if (m_stall !== 1'b0) begin
      fails++;
      $display("FAIL itype_stall: m_stall=%b, required 0", m_stall);
    end
    @(negedge clk);
    m_valid = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  initial begin
    rst_n      = 1'b0;
    m_valid    = 1'b0;
    exe_alu_op = 3'b000;
    exe_funct3 = 3'b000;
    exe_funct7 = 7'b0000000;
    rs1_data   = 32'h0;
    rs2_data   = 32'h0;
    flush      = 1'b0;

    test_reset();
    test_mul();
    test_div();
    test_fast();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    test_non_m();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for RV32M MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU in the EXE stage, alongside the single-cycle ALU.
- Detects M-extension R-type ops from the same exe_alu_op/funct3/funct7 fields the ALU control decodes.
- Runs an iterative radix-2 shift-add multiply or restoring divide, holds the pipeline with m_stall, and returns one result with a done pulse.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  core clock
- rst_n  input  1  synchronous active-low reset
- m_valid  input  1  EXE holds a valid instruction
- exe_alu_op  input  3  ALU op class; 3'b000 = R-type
- exe_funct3  input  3  selects the M operation
- exe_funct7  input  7  7'b0000001 marks an M op
- rs1_data  input  XLEN  forwarded operand A
- rs2_data  input  XLEN  forwarded operand B
- flush  input  1  kill the in-flight op (branch or jump redirect)
- m_stall  output  1  freeze IF/ID/EXE this cycle
- m_done  output  1  one-cycle pulse; m_result valid
- m_result  output  XLEN  result, held until the next accept

Behaviour:
- Start condition: start = m_valid & exe_alu_op==3'b000 & exe_funct7==7'b0000001 & state==IDLE & !flush.
- States: IDLE, CALC, DONE.
- Reset (rst_n==0 at a clk edge): state=IDLE, counter=0, accumulators=0, m_result=0, m_done=0, m_stall=0. Reset mid-op abandons the op and produces no done.
- IDLE
  - On start, latch the op, operand magnitudes and sign flags.
  - Signedness: MUL/MULH/DIV/REM treat both operands as signed; MULHSU treats only rs1 as signed; the U variants treat both as unsigned.
  - Next state: CALC with counter=0, except the fast cases below, which go to DONE.
- Fast cases (go directly to DONE):
  - DIV/DIVU with rs2==0: quotient=all ones.
  - REM/REMU with rs2==0: remainder=rs1.
  - DIV with rs1==0x80000000 and rs2==0xFFFFFFFF: quotient=0x80000000.
  - REM with the same operands: remainder=0.
- CALC
  - One iteration per cycle for XLEN cycles; leave CALC when counter==XLEN-1.
  - Multiply: 2*XLEN-bit product register, shift-add on magnitudes.
  - Divide: restoring divide with an XLEN+1-bit trial subtraction.
- DONE
  - Apply sign correction:
    - product sign = sA^sB;
    - quotient sign = sA^sB;
    - remainder sign = sA.
  - Select the output half: MUL = low XLEN bits; MULH/MULHSU/MULHU = high XLEN bits.
  - Register m_result; m_done=1 for exactly this cycle; next state is IDLE unconditionally. Start is never sampled in DONE.
- m_stall (combinational):
  - 1 when start is asserted in IDLE, and for every CALC cycle;
  - 0 in DONE, so the pipeline advances on that edge;
  - 0 whenever flush=1.
- Latency from the accept edge:
  - normal ops: XLEN CALC cycles, then DONE, so m_done rises XLEN+1 cycles after accept (33);
  - fast cases: m_done rises 1 cycle after accept.
- Flush: flush=1 in CALC or DONE forces IDLE on the next edge; m_done is suppressed in that cycle and m_result is left unchanged.
- Simultaneous flush and start in IDLE: flush wins; nothing is accepted.
- Non-M ops: no effect; stay IDLE with m_stall=0.

Decomposition:
- Shared package (riscv_pkg):
  - the ALU op-class codes (r_type=3'b000 etc.) already used by alu_ctrl;
  - FUNCT7_MULDIV=7'b0000001;
  - funct3 localparams F3_MUL through F3_REMU;
  - enum muldiv_state_t {IDLE, CALC, DONE}.
- Sub-module muldiv_dp: accumulator, trial subtractor, counter, sign fix-up and output mux. It has no FSM.
- muldiv_seq holds the FSM, decode, the stall/done logic and the instance of muldiv_dp.

Test Plan:
- MUL 7 * 0xFFFFFFFD -> m_result=0xFFFFFFEB; m_done exactly 33 cycles after accept; m_stall high for 33 cycles, low in the done cycle.
- MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULH of the same operands -> 0x00000000. MULHSU 0xFFFFFFFF,0x00000002 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 -> 0xFFFFFFFD. REM same operands -> 0xFFFFFFFF. DIVU 100/7 -> 14. REMU 100/7 -> 2.
- Fast cases, each with m_done 1 cycle after accept:
  - DIV 5/0 -> 0xFFFFFFFF;
  - REMU 5/0 -> 5;
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000;
  - REM same operands -> 0.
- Flush or reset during CALC:
  - flush at cycle 10 of CALC -> no m_done; IDLE next cycle; a fresh MUL 3*4 then returns 12;
  - rst_n=0 at cycle 5 of CALC -> all outputs 0 on the next edge.
- Back-to-back MUL then DIV in consecutive instructions -> the DIV is accepted the cycle after DONE, never during DONE; results are in order.
- An ADD with m_valid=1 -> m_stall stays 0, no m_done.
